uart_rx: RTL and testbench

UART receiver that deserialises the asynchronous `rx` line into parallel bytes. It sits directly downstream of `uart_generator_clock` and consumes that block's `sample_clk`. Every edge of `sample_clk` (rising or falling) is treated as one oversampling tick, so ticks arrive at `SAMPLE × BAUD_RATE`. Received words are held in a one-entry output register with a valid/ready handshake toward the host-side logic.

---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with a one-entry valid/ready output register
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int SAMPLE     = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_clk,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int TW = $clog2(SAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(SAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(SAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic                 sc_q;
  logic                 rx_prev_q;
  logic                 par_err_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [TW-1:0]        tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_s;
  logic                 tick;
  logic                 at_mid;
  logic                 at_end;
  logic                 last_stop;
  logic                 deliver_d;
  logic                 par_bad_d;

  // Tick detection, counter wrap and frame-completion decode
  always_comb begin
    rx_s       = sync_q[1];
    tick       = sample_clk ^ sc_q;
    at_mid     = tick_cnt_q == T_MID;
    at_end     = tick_cnt_q == T_END;
    tick_cnt_d = at_end ? '0 : tick_cnt_q + TW'(1);
    last_stop  = (STOP_BITS == 1) || (bit_cnt_q == BW'(1));
    par_bad_d  = (^shift_q ^ rx_s) != 1'(PARITY_ODD);
    deliver_d  = tick && state_q == STOP && at_end && rx_s && last_stop && !par_err_q;
  end

  // Line synchroniser, sample_clk edge history and per-tick line history
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q    <= 2'b11;
      sc_q      <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      sc_q   <= sample_clk;
      if (tick) rx_prev_q <= rx_s;
    end

  // Frame FSM with registered status, error pulses and output handshake
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= deliver_d && rx_valid && !rx_ready;
      if (deliver_d && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (tick) begin
        case (state_q)
          IDLE: if (rx_prev_q && !rx_s) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            busy       <= 1'b1;
          end
          START: begin
            tick_cnt_q <= tick_cnt_d;
            if (at_mid) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              par_err_q  <= 1'b0;
              state_q    <= rx_s ? IDLE : DATA;
              busy       <= !rx_s;
            end
          end
          DATA: begin
            tick_cnt_q <= tick_cnt_d;
            if (at_end) begin
              shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == B_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= (PARITY_EN != 0) ? PARITY : STOP;
              end
            end
          end
          PARITY: begin
            tick_cnt_q <= tick_cnt_d;
            if (at_end) begin
              par_err_q <= par_bad_d;
              state_q   <= STOP;
            end
          end
          STOP: begin
            tick_cnt_q <= tick_cnt_d;
            if (at_end) begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              if (!rx_s || last_stop) begin
                state_q    <= IDLE;
                busy       <= 1'b0;
                bit_cnt_q  <= '0;
                frame_err  <= !rx_s;
                parity_err <= rx_s && par_err_q;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level event model checked every cycle against an 8N1 and an 8E1 receiver
module tb_uart_rx;
  localparam int BIT    = 64;
  localparam int TK     = 40;
  localparam int K_NONE = 0;
  localparam int K_DEL  = 1;
  localparam int K_FE   = 2;
  localparam int K_PE   = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_clk = 1'b0;
  logic       rx [2];
  logic       rx_ready [2];
  logic [7:0] rx_data [2];
  logic       rx_valid [2];
  logic       busy [2];
  logic       frame_err [2];
  logic       parity_err [2];
  logic       overrun [2];
  logic [7:0] m_data [2];
  logic       m_valid [2];
  logic       m_busy [2];
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    int         u;
    time        bs;
    time        te;
    int         kind;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;
  always #40 sample_clk = ~sample_clk;

  uart_rx u0 (
    .clk(clk), .reset_n(reset_n), .sample_clk(sample_clk), .rx(rx[0]), .rx_ready(rx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]), .frame_err(frame_err[0]),
    .parity_err(parity_err[0]), .overrun(overrun[0])
  );

  uart_rx #(.PARITY_EN(1)) u1 (
    .clk(clk), .reset_n(reset_n), .sample_clk(sample_clk), .rx(rx[1]), .rx_ready(rx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]), .frame_err(frame_err[1]),
    .parity_err(parity_err[1]), .overrun(overrun[1])
  );

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d at %0t: got %0h, want %0h", nm, u, $time, act, exp);
    end
  endtask

  // Start edge driven now; detect is the first tick edge at least 2 sync clocks later,
  // the outcome appears at the tick sampling stop bit n (or mid start bit for a glitch).
  task automatic push(input int u, input int kind, input logic [7:0] d, input int n, output time te);
    ev_t e;
    time det;
    det = TK * (($time + 20 + TK - 1) / TK) + 5;
    te = (kind == K_NONE) ? det + 8 * TK : det + TK * (8 + 16 * n);
    e.u = u;
    e.bs = det;
    e.te = te;
    e.kind = kind;
    e.d = d;
    evq.push_back(e);
  endtask

  task automatic send(input int u, input logic [7:0] d, input int pb, input logic stop,
                      input bit rdy, output time te);
    int kind;
    kind = !stop ? K_FE : (pb >= 0 && (^d ^ pb[0])) ? K_PE : K_DEL;
    rx[u] = 1'b0;
    push(u, kind, d, (pb >= 0) ? 10 : 9, te);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[u] = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (pb >= 0) begin
      rx[u] = pb[0];
      repeat (BIT) @(negedge clk);
    end
    rx[u] = stop;
    for (int i = 0; i < BIT; i++) begin
      if (rdy && $time == te - 5) rx_ready[u] = 1'b1;
      if (rdy && $time == te + 5) rx_ready[u] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin : cmp
    time  tp;
    logic ev;
    logic ld;
    logic ov;
    int   k;
    forever begin
      @(posedge clk);
      tp = $time;
      #1;
      for (int u = 0; u < 2; u++) begin
        ev = 1'b0;
        ld = 1'b0;
        ov = 1'b0;
        k = K_NONE;
        if (!reset_n) begin
          m_valid[u] = 1'b0;
          m_busy[u] = 1'b0;
          m_data[u] = 8'h00;
        end else begin
          if (evq.size() > 0 && evq[0].u == u && evq[0].bs == tp) m_busy[u] = 1'b1;
          if (evq.size() > 0 && evq[0].u == u && evq[0].te == tp) begin
            ev = 1'b1;
            k = evq[0].kind;
            m_busy[u] = 1'b0;
          end
          ld = ev && k == K_DEL && (!m_valid[u] || rx_ready[u]);
          ov = ev && k == K_DEL && m_valid[u] && !rx_ready[u];
          if (ld) begin
            m_data[u] = evq[0].d;
            m_valid[u] = 1'b1;
          end else if (rx_ready[u]) begin
            m_valid[u] = 1'b0;
          end
          if (ev) void'(evq.pop_front());
        end
        chk("rx_valid", u, rx_valid[u], m_valid[u]);
        chk("rx_data", u, rx_data[u], m_data[u]);
        chk("busy", u, busy[u], m_busy[u]);
        chk("frame_err", u, frame_err[u], ev && k == K_FE);
        chk("parity_err", u, parity_err[u], ev && k == K_PE);
        chk("overrun", u, overrun[u], ov);
      end
      if (!reset_n) evq.delete();
    end
  end

  initial begin : stim
    time        te;
    logic [7:0] v;
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    rx_ready[0] = 1'b0;
    rx_ready[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    send(0, 8'hA5, -1, 1'b1, 1'b0, te);
    chk("a5_data", 0, rx_data[0], 32'hA5);
    chk("a5_valid", 0, rx_valid[0], 32'h1);
    repeat (30) @(negedge clk);
    chk("a5_hold", 0, rx_valid[0], 32'h1);
    rx_ready[0] = 1'b1;
    @(negedge clk);
    rx_ready[0] = 1'b0;
    chk("a5_consumed", 0, rx_valid[0], 32'h0);
    repeat (20) @(negedge clk);

    rx[0] = 1'b0;
    push(0, K_NONE, 8'h00, 0, te);
    repeat ((te - 8 * TK + 125 - $time) / 10) @(negedge clk);
    rx[0] = 1'b1;
    repeat (120) @(negedge clk);
    chk("glitch_valid", 0, rx_valid[0], 32'h0);
    chk("glitch_busy", 0, busy[0], 32'h0);

    send(0, 8'h3C, -1, 1'b0, 1'b0, te);
    repeat (1500) @(negedge clk);
    chk("break_valid", 0, rx_valid[0], 32'h0);
    chk("break_busy", 0, busy[0], 32'h0);
    rx[0] = 1'b1;
    repeat (200) @(negedge clk);

    send(0, 8'h11, -1, 1'b1, 1'b0, te);
    send(0, 8'h22, -1, 1'b1, 1'b0, te);
    chk("ovr_data", 0, rx_data[0], 32'h11);
    chk("ovr_valid", 0, rx_valid[0], 32'h1);
    rx_ready[0] = 1'b1;
    @(negedge clk);
    rx_ready[0] = 1'b0;
    repeat (20) @(negedge clk);
    send(0, 8'h11, -1, 1'b1, 1'b0, te);
    send(0, 8'h22, -1, 1'b1, 1'b1, te);
    chk("swap_data", 0, rx_data[0], 32'h22);
    chk("swap_valid", 0, rx_valid[0], 32'h1);
    repeat (20) @(negedge clk);

    send(1, 8'h07, 0, 1'b1, 1'b0, te);
    chk("par_bad_valid", 1, rx_valid[1], 32'h0);
    send(1, 8'h07, 1, 1'b1, 1'b0, te);
    chk("par_ok_data", 1, rx_data[1], 32'h07);
    chk("par_ok_valid", 1, rx_valid[1], 32'h1);
    repeat (50) @(negedge clk);

    v = 8'h5A;
    rx[0] = 1'b0;
    push(0, K_DEL, v, 9, te);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx[0] = v[i];
      repeat (BIT) @(negedge clk);
    end
    chk("mid_busy", 0, busy[0], 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 0, rx_valid[0], 32'h0);
    chk("rst_data", 0, rx_data[0], 32'h0);
    chk("rst_busy", 0, busy[0], 32'h0);
    chk("rst_valid", 1, rx_valid[1], 32'h0);
    rx[0] = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    send(0, 8'hC3, -1, 1'b1, 1'b0, te);
    chk("c3_data", 0, rx_data[0], 32'hC3);
    chk("c3_valid", 0, rx_valid[0], 32'h1);
    repeat (50) @(negedge clk);
    chk("events_done", 0, evq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
